// File: rtl/exc_sched_pkg.sv
// Shared CPU definitions for the exception scheduler.
// Holds the Cause.ExcCode constants, the default handler entry address and
// the scheduler FSM state encoding. Imported by exc_sched.
package exc_sched_pkg;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Default exception/interrupt handler entry
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EXC_FLUSH  = 2'd1,
    ERET_FLUSH = 2'd2,
    REDIRECT   = 2'd3
  } state_t;

endpackage

// File: rtl/exc_sched.sv
// Exception / interrupt scheduler.
// Watches the M stage and the interrupt lines, and sequences the pipeline
// through flush + redirect when an exception, interrupt or ERET is taken.
// CP0 register storage lives outside; this block only emits the update
// strobes (take, eret_ack) and the values CP0 latches with them.
//
// Ports:
//   clk, reset            clock, async active-low reset
//   hw_int[5:0]           level interrupt lines
//   sr_im, sr_ie, sr_exl  CP0 SR fields (mask, global enable, exception level)
//   m_valid, m_exc, m_exc_code, m_bd, m_eret   M stage status
//   epc                   current CP0 EPC (ERET return target)
//   take                  pulse: CP0 latches EPC/Cause/BD, sets EXL
//   exc_code, exc_bd      Cause.ExcCode / Cause.BD for the taken event
//   ip                    registered hw_int, for Cause.IP
//   eret_ack              pulse: CP0 clears EXL
//   flush                 kill F/D/E/M pipeline registers
//   redirect, redirect_pc fetch redirect strobe and target (0 when idle)
//   busy                  scheduler is sequencing
module exc_sched
  import exc_sched_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hw_int,
  input  logic [5:0]  sr_im,
  input  logic        sr_ie,
  input  logic        sr_exl,
  input  logic        m_valid,
  input  logic        m_exc,
  input  logic [4:0]  m_exc_code,
  input  logic        m_bd,
  input  logic        m_eret,
  input  logic [31:0] epc,
  output logic        take,
  output logic [4:0]  exc_code,
  output logic        exc_bd,
  output logic [5:0]  ip,
  output logic        eret_ack,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  state_t state;
  logic   irq_pend;

  assign irq_pend = sr_ie & ~sr_exl & (|(ip & sr_im));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ip <= '0;
    else        ip <= hw_int;
  end

  // All outputs are registered alongside the state so each one is a clean
  // Moore decode of the state it belongs to. Requests arriving while busy
  // are simply not looked at; a held interrupt is seen again in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      take        <= 1'b0;
      eret_ack    <= 1'b0;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      exc_code    <= '0;
      exc_bd      <= 1'b0;
    end else begin
      take        <= 1'b0;
      eret_ack    <= 1'b0;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      case (state)
        IDLE: begin
          // Interrupt is only attached to a real instruction so EPC is valid.
          if (irq_pend && m_valid) begin
            state    <= EXC_FLUSH;
            exc_code <= EXC_INT;
            exc_bd   <= m_bd;
            take     <= 1'b1;
            flush    <= 1'b1;
          end else if (m_exc && !sr_exl) begin
            state    <= EXC_FLUSH;
            exc_code <= m_exc_code;
            exc_bd   <= m_bd;
            take     <= 1'b1;
            flush    <= 1'b1;
          end else if (m_eret) begin
            state    <= ERET_FLUSH;
            eret_ack <= 1'b1;
            flush    <= 1'b1;
          end
        end
        EXC_FLUSH: begin
          state       <= REDIRECT;
          redirect    <= 1'b1;
          flush       <= 1'b1;
          redirect_pc <= HANDLER_PC;
        end
        ERET_FLUSH: begin
          // EPC is sampled here, after CP0 has seen eret_ack.
          state       <= REDIRECT;
          redirect    <= 1'b1;
          flush       <= 1'b1;
          redirect_pc <= epc;
        end
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_sched.sv
module tb_exc_sched;
  import exc_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  hw_int = '0, sr_im = '0;
  logic        sr_ie = 0, sr_exl = 0, m_valid = 0, m_exc = 0, m_bd = 0, m_eret = 0;
  logic [4:0]  m_exc_code = '0;
  logic [31:0] epc = '0;
  logic        take, exc_bd, eret_ack, flush, redirect, busy;
  logic [4:0]  exc_code;
  logic [5:0]  ip;
  logic [31:0] redirect_pc;

  exc_sched dut (
    .clk(clk), .reset(reset), .hw_int(hw_int), .sr_im(sr_im), .sr_ie(sr_ie),
    .sr_exl(sr_exl), .m_valid(m_valid), .m_exc(m_exc), .m_exc_code(m_exc_code),
    .m_bd(m_bd), .m_eret(m_eret), .epc(epc), .take(take), .exc_code(exc_code),
    .exc_bd(exc_bd), .ip(ip), .eret_ack(eret_ack), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: kind 0=take, 1=eret_ack, 2=redirect
  typedef struct {
    int          kind;
    logic [4:0]  code;
    logic        bd;
    logic [31:0] pc;
  } ev_t;
  ev_t exp_q[$];
  bit  sb_on = 0;

  task automatic push_ev(input int kind, input logic [4:0] code, input logic bd,
                         input logic [31:0] pc);
    ev_t e;
    e.kind = kind; e.code = code; e.bd = bd; e.pc = pc;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_on) begin
      if (take || eret_ack || redirect) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {29'd0, redirect, eret_ack, take}, 32'd0);
        end else begin
          ev_t e;
          int  k;
          e = exp_q.pop_front();
          k = take ? 0 : (eret_ack ? 1 : 2);
          chk("event_kind", k, e.kind);
          chk("event_onehot", 32'(take) + 32'(eret_ack) + 32'(redirect), 32'd1);
          chk("event_flush", {31'd0, flush}, 32'd1);
          if (k == 0) begin
            chk("take_code", {27'd0, exc_code}, {27'd0, e.code});
            chk("take_bd", {31'd0, exc_bd}, {31'd0, e.bd});
          end
          if (k == 2) chk("redirect_pc", redirect_pc, e.pc);
        end
      end else if (redirect_pc != 32'd0) begin
        chk("redirect_pc_idle", redirect_pc, 32'd0);
      end
    end
  end

  typedef struct {
    logic [5:0]  hw;
    logic [5:0]  im;
    logic        ie, exl, mv, exc;
    logic [4:0]  code;
    logic        bd, eret;
    logic [31:0] epc;
    int          ev;      // 0 none, 1 take+redirect, 2 eret+redirect
    logic [4:0]  e_code;
    logic        e_bd;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[12];

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    vt[0]  = '{6'h00, 6'h00, 1, 0, 1, 1, EXC_OV,   1, 0, 32'h0,          1, EXC_OV,   1, 32'h0000_4180};
    vt[1]  = '{6'h01, 6'h01, 1, 0, 1, 0, 5'd0,     0, 0, 32'h0,          1, EXC_INT,  0, 32'h0000_4180};
    vt[2]  = '{6'h01, 6'h01, 1, 0, 1, 1, EXC_RI,   1, 0, 32'h0,          1, EXC_INT,  1, 32'h0000_4180};
    vt[3]  = '{6'h00, 6'h00, 1, 0, 1, 0, 5'd0,     0, 1, 32'h0000_3010,  2, 5'd0,     0, 32'h0000_3010};
    vt[4]  = '{6'h01, 6'h01, 1, 1, 1, 0, 5'd0,     0, 0, 32'h0,          0, 5'd0,     0, 32'h0};
    vt[5]  = '{6'h04, 6'h04, 1, 0, 0, 0, 5'd0,     0, 0, 32'h0,          0, 5'd0,     0, 32'h0};
    vt[6]  = '{6'h00, 6'h00, 1, 1, 1, 1, EXC_ADEL, 0, 0, 32'h0,          0, 5'd0,     0, 32'h0};
    vt[7]  = '{6'h00, 6'h00, 1, 0, 1, 1, EXC_ADEL, 0, 0, 32'h0,          1, EXC_ADEL, 0, 32'h0000_4180};
    vt[8]  = '{6'h20, 6'h1F, 1, 0, 1, 0, 5'd0,     0, 0, 32'h0,          0, 5'd0,     0, 32'h0};
    vt[9]  = '{6'h02, 6'h02, 0, 0, 1, 0, 5'd0,     0, 0, 32'h0,          0, 5'd0,     0, 32'h0};
    vt[10] = '{6'h00, 6'h00, 1, 0, 1, 1, EXC_ADES, 0, 1, 32'h0000_2000,  1, EXC_ADES, 0, 32'h0000_4180};
    vt[11] = '{6'h00, 6'h00, 1, 1, 1, 0, 5'd0,     0, 1, 32'hBFC0_0100,  2, 5'd0,     0, 32'hBFC0_0100};

    // Reset state: held with clocks running and hw_int active
    hw_int = 6'h3F;
    repeat (3) @(negedge clk);
    chk("rst_ip", {26'd0, ip}, 32'd0);
    chk("rst_pulses", {28'd0, take, eret_ack, flush, redirect}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_code_bd", {26'd0, exc_code, exc_bd}, 32'd0);
    chk("rst_pc", redirect_pc, 32'd0);
    hw_int = '0;
    reset  = 1'b1;
    @(negedge clk);
    sb_on = 1;

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      hw_int = vt[i].hw; sr_im = vt[i].im; sr_ie = vt[i].ie;
      sr_exl = vt[i].exl; m_valid = vt[i].mv;
      @(negedge clk);
      if (vt[i].hw != 0) chk($sformatf("v%0d_ip", i), {26'd0, ip}, {26'd0, vt[i].hw});
      m_exc = vt[i].exc; m_exc_code = vt[i].code; m_bd = vt[i].bd;
      m_eret = vt[i].eret; epc = vt[i].epc;
      if (vt[i].ev == 1) begin
        push_ev(0, vt[i].e_code, vt[i].e_bd, 32'h0);
        push_ev(2, 5'd0, 1'b0, vt[i].e_pc);
      end else if (vt[i].ev == 2) begin
        push_ev(1, 5'd0, 1'b0, 32'h0);
        push_ev(2, 5'd0, 1'b0, vt[i].e_pc);
      end
      @(negedge clk);
      m_exc = 0; m_eret = 0; hw_int = '0;
      wait_idle($sformatf("v%0d", i));
      repeat (2) @(negedge clk);
      if (i == 0) chk("code_held", {26'd0, exc_code, exc_bd}, {26'd0, EXC_OV, 1'b1});
    end

    // Held interrupt blocked by EXL, then by m_valid=0, then taken
    hw_int = 6'h01; sr_im = 6'h01; sr_ie = 1; sr_exl = 1; m_valid = 1;
    repeat (3) @(negedge clk);
    chk("exl_block", {31'd0, take}, 32'd0);
    sr_exl = 0; m_valid = 0;
    repeat (3) @(negedge clk);
    chk("mvalid_block", {31'd0, take}, 32'd0);
    m_valid = 1;
    push_ev(0, EXC_INT, 1'b0, 32'h0);
    push_ev(2, 5'd0, 1'b0, 32'h0000_4180);
    @(negedge clk);
    chk("irq_take_next", {31'd0, take}, 32'd1);
    hw_int = '0;
    wait_idle("irq_release");
    repeat (2) @(negedge clk);

    // EPC sampled in the ERET_FLUSH cycle, not the request cycle
    m_eret = 1; epc = 32'h0000_1111;
    push_ev(1, 5'd0, 1'b0, 32'h0);
    push_ev(2, 5'd0, 1'b0, 32'h0000_2222);
    @(negedge clk);
    m_eret = 0; epc = 32'h0000_2222;
    wait_idle("eret_epc");
    repeat (2) @(negedge clk);

    // Busy width and redirect latency
    begin
      int bcnt = 0, rpos = -1;
      m_exc = 1; m_exc_code = EXC_RI; m_bd = 0;
      push_ev(0, EXC_RI, 1'b0, 32'h0);
      push_ev(2, 5'd0, 1'b0, 32'h0000_4180);
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        m_exc = 0;
        if (busy) bcnt++;
        if (redirect && rpos < 0) rpos = c;
      end
      chk("busy_cycles", bcnt, 32'd2);
      chk("redirect_latency", rpos, 32'd2);
      wait_idle("busy");
    end

    // Reset during REDIRECT
    sb_on = 0;
    m_exc = 1; m_exc_code = EXC_OV;
    @(negedge clk);
    m_exc = 0;
    @(negedge clk);
    chk("pre_rst_redirect", {31'd0, redirect}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_outs", {28'd0, redirect, flush, busy, take}, 32'd0);
    chk("rst_mid_pc", redirect_pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    begin
      logic seen = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        seen |= take | eret_ack | redirect | busy;
      end
      chk("post_rst_quiet", {31'd0, seen}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exc_sched.md
EXC_SCHED -- requirements
Module: exc_sched

Interface
REQ-001 SHALL have parameter HANDLER_PC, default 32'h0000_4180, exception/interrupt handler entry address.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port hw_int  in  6  level interrupt lines (IRQ0, IRQ1, external, spare).
REQ-005 SHALL have port sr_im  in  6  interrupt mask, CP0 SR[15:10].
REQ-006 SHALL have port sr_ie  in  1  global interrupt enable, CP0 SR[0].
REQ-007 SHALL have port sr_exl  in  1  exception level, CP0 SR[1].
REQ-008 SHALL have port m_valid  in  1  M stage holds a real instruction, not a bubble.
REQ-009 SHALL have port m_exc  in  1  M stage synchronous exception present.
REQ-010 SHALL have port m_exc_code  in  5  cause ExcCode of the M stage exception.
REQ-011 SHALL have port m_bd  in  1  M stage instruction is in a branch delay slot.
REQ-012 SHALL have port m_eret  in  1  M stage instruction is ERET.
REQ-013 SHALL have port epc  in  32  current CP0 EPC value.
REQ-014 SHALL have port take  out  1  one-cycle pulse: CP0 latches EPC/Cause/BD and sets EXL.
REQ-015 SHALL have port exc_code  out  5  ExcCode to write into Cause[6:2].
REQ-016 SHALL have port exc_bd  out  1  BD value to write into Cause[31].
REQ-017 SHALL have port ip  out  6  registered hw_int, for Cause[15:10].
REQ-018 SHALL have port eret_ack  out  1  one-cycle pulse: CP0 clears EXL.
REQ-019 SHALL have port flush  out  1  kill F/D/E/M pipeline registers.
REQ-020 SHALL have port redirect  out  1  fetch PC SHALL load redirect_pc.
REQ-021 SHALL have port redirect_pc  out  32  target PC.
REQ-022 SHALL have port busy  out  1  state is not IDLE.

Function
REQ-023 ip SHALL be hw_int registered every cycle (one-cycle latency).
REQ-024 irq_pend SHALL be sr_ie & ~sr_exl & |(ip & sr_im).
REQ-025 FSM states SHALL be IDLE, EXC_FLUSH, ERET_FLUSH, REDIRECT; outputs SHALL be Moore (decoded from registers).
REQ-026 In IDLE, priority SHALL be: irq_pend & m_valid -> EXC_FLUSH, code 0; else m_exc & ~sr_exl -> EXC_FLUSH, code m_exc_code; else m_eret -> ERET_FLUSH; else stay.
REQ-027 On IDLE->EXC_FLUSH, exc_code and exc_bd (from m_bd) SHALL be latched and held until the next such transition.
REQ-028 EXC_FLUSH SHALL assert take=1 and flush=1 for exactly one cycle, then go to REDIRECT with target HANDLER_PC.
REQ-029 ERET_FLUSH SHALL assert eret_ack=1 and flush=1 for one cycle, then go to REDIRECT with target epc sampled in the ERET_FLUSH cycle.
REQ-030 REDIRECT SHALL assert redirect=1 and flush=1 with redirect_pc held for one cycle, then return to IDLE.
REQ-031 redirect_pc SHALL be 0 when redirect=0.
REQ-032 While busy=1, m_exc, m_eret and irq_pend SHALL be ignored; a still-asserted interrupt SHALL be re-evaluated in IDLE.
REQ-033 Interrupt with m_valid=0 SHALL wait in IDLE until m_valid=1.
REQ-034 Exception-to-redirect latency SHALL be 2 cycles after detection edge; busy SHALL be 1 for exactly 2 cycles.

Reset
REQ-035 reset low SHALL immediately force IDLE, ip=0, exc_code=0, exc_bd=0, all pulse outputs 0, redirect_pc=0, busy=0, regardless of clk.
REQ-036 Reset deassertion mid-sequence SHALL resume in IDLE with no take, eret_ack or redirect issued.

Structure
REQ-037 ExcCode constants (INT=0, ADEL=4, ADES=5, RI=10, OV=12), HANDLER_PC and state encoding SHALL live in the shared CPU definitions include.
REQ-038 The block SHALL be one module, no sub-modules; CP0 register storage SHALL remain outside.

Verification
REQ-039 m_exc=1, m_exc_code=12, m_bd=1, sr_exl=0 -> next cycle take=1, exc_code=12, exc_bd=1, flush=1; following cycle redirect=1, redirect_pc=0x00004180.
REQ-040 hw_int=6'b000001, sr_im[0]=1, sr_ie=1, sr_exl=0, m_valid=1 -> ip set after 1 cycle, then take=1 with exc_code=0 and redirect to 0x00004180.
REQ-041 Interrupt and m_exc (code 10) in same cycle -> exc_code=0; code 10 never reported during that sequence.
REQ-042 m_eret=1, epc=0x00003010 -> eret_ack=1, flush=1, then redirect=1, redirect_pc=0x00003010; take stays 0.
REQ-043 Pending interrupt with sr_exl=1, or with m_valid=0 -> no take; clearing sr_exl and setting m_valid=1 -> take next cycle.
REQ-044 reset low during REDIRECT -> redirect, flush, busy drop immediately; after release, no redirect without a new request.
